cache_mem_bridge: RTL and testbench

- Memory-side stage directly downstream of the two-way cache; sits between the cache's refill/writeback port and main memory.
- Buffers cache→memory requests and pipelines up to MAX_OUTSTANDING of them to memory.
- Retags the opaque field with a local sequence id, checks in-order return, restores the original opaque, and buffers responses back to the cache.
- Provides a drain handshake used alongside cache flush.

---
 rtl/cache_mem_bridge_pkg.sv | 44 ++++
 rtl/cache_mem_bridge_fifo.sv | 82 ++++++++
 rtl/cache_mem_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_bridge_pkg.sv
// Shared types and constants for cache_mem_bridge.
// Message layouts mirror the 4-byte memory request/response formats used
// between the two-way cache and main memory.
package cache_mem_bridge_pkg;

  localparam int DEF_REQ_DEPTH       = 32'sd4;
  localparam int DEF_RESP_DEPTH      = 32'sd2;
  localparam int DEF_MAX_OUTSTANDING = 32'sd4;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // One request-FIFO slot: the cache request exactly as received, so the
  // original opaque is still available when the entry is issued.
  typedef struct packed {
    mem_req_4B_t msg;
  } req_entry_t;

  // Width of a sequence id; at least one bit even for tiny limits.
  function automatic int id_width(input int n);
    if (n <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/cache_mem_bridge_fifo.sv
// Circular-buffer FIFO with synchronous active-low reset.
// Enqueue is refused when full (even if a dequeue happens the same cycle);
// the head is always visible on deq_data when the FIFO is not empty.
module cache_mem_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq_rdy,
  output logic [WIDTH-1:0]         deq_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             enq_fire_s;
  logic             deq_fire_s;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == CNT_ZERO);
  assign count      = count_q;
  assign deq_data   = mem_q[rd_ptr_q];
  assign enq_fire_s = enq_val && !full;
  assign deq_fire_s = deq_rdy && !empty;

  // Next pointer, occupancy and storage contents from this cycle's transfers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire_s) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_fire_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_fire_s, deq_fire_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: buffers cache refill/writeback requests, issues up to
// MAX_OUTSTANDING of them to memory under local sequence ids, restores the
// original opaque on the way back and flags out-of-order returns.
// Optional build macro CACHE_MEM_BRIDGE_STATS_EN adds issue/stall counters.
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int REQ_DEPTH       = DEF_REQ_DEPTH,
  parameter int RESP_DEPTH      = DEF_RESP_DEPTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cachereq_val,
  output logic         cachereq_rdy,
  input  mem_req_4B_t  cachereq_msg,
  output logic         cacheresp_val,
  input  logic         cacheresp_rdy,
  output mem_resp_4B_t cacheresp_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  output mem_req_4B_t  memreq_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  mem_resp_4B_t memresp_msg,
  input  logic         drain,
  output logic         drain_done,
  output logic         err_seq
`ifdef CACHE_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]  stat_req_cnt,
  output logic [31:0]  stat_stall_cnt
`endif
);

  localparam int ID_W  = id_width(MAX_OUTSTANDING);
  localparam int CNT_W = ID_W + 1;
  localparam int RQ_CW = $clog2(REQ_DEPTH) + 1;
  localparam int RS_CW = $clog2(RESP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);

  logic             req_full_s, req_empty_s;
  logic [RQ_CW-1:0] req_count_s;
  logic             resp_full_s, resp_empty_s;
  logic [RS_CW-1:0] resp_count_s;
  req_entry_t       req_in_s, req_head_s;
  mem_resp_4B_t     resp_enq_s;
  logic [ID_W-1:0]  resp_id_s;
  logic             req_enq_s, issue_fire_s, resp_fire_s, cresp_fire_s;

  logic [ID_W-1:0]  issue_id_q, issue_id_d;
  logic [ID_W-1:0]  expect_id_q, expect_id_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_seq_q, err_seq_d;
  logic             drain_done_q, drain_done_d;
  logic [7:0]       opaque_tbl_q [MAX_OUTSTANDING];
  logic [7:0]       opaque_tbl_d [MAX_OUTSTANDING];
`ifdef CACHE_MEM_BRIDGE_STATS_EN
  logic [31:0]      stat_req_q, stat_req_d;
  logic [31:0]      stat_stall_q, stat_stall_d;
`endif

  // Handshake outputs; all forced low while reset is asserted.
  assign cachereq_rdy  = reset && !req_full_s && !drain;
  assign memreq_val    = reset && !req_empty_s && (outstanding_q < MAX_CNT);
  assign memresp_rdy   = reset && !resp_full_s;
  assign cacheresp_val = reset && !resp_empty_s;

  assign req_enq_s     = cachereq_val && cachereq_rdy;
  assign issue_fire_s  = memreq_val && memreq_rdy;
  assign resp_fire_s   = memresp_val && memresp_rdy;
  assign cresp_fire_s  = cacheresp_val && cacheresp_rdy;
  assign req_in_s.msg  = cachereq_msg;

  assign drain_done    = drain_done_q;
  assign err_seq       = err_seq_q;

  cache_mem_bridge_fifo #(
    .WIDTH ($bits(req_entry_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_enq_s),
    .enq_data (req_in_s),
    .deq_rdy  (issue_fire_s),
    .deq_data (req_head_s),
    .full     (req_full_s),
    .empty    (req_empty_s),
    .count    (req_count_s)
  );

  cache_mem_bridge_fifo #(
    .WIDTH ($bits(mem_resp_4B_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (resp_fire_s),
    .enq_data (resp_enq_s),
    .deq_rdy  (cresp_fire_s),
    .deq_data (cacheresp_msg),
    .full     (resp_full_s),
    .empty    (resp_empty_s),
    .count    (resp_count_s)
  );

  // Message retagging: outgoing opaque becomes the sequence id, returning
  // opaque is restored from the table slot named by the returned id.
  always_comb begin
    memreq_msg        = req_head_s.msg;
    memreq_msg.opaque = 8'(issue_id_q);
    resp_id_s         = memresp_msg.opaque[ID_W-1:0];
    resp_enq_s        = memresp_msg;
    resp_enq_s.opaque = opaque_tbl_q[resp_id_s];
  end

  // Next-state for sequence ids, outstanding count, error flag and drain.
  always_comb begin
    issue_id_d    = issue_id_q;
    expect_id_d   = expect_id_q;
    outstanding_d = outstanding_q;
    err_seq_d     = err_seq_q;
    opaque_tbl_d  = opaque_tbl_q;
    if (issue_fire_s) begin
      opaque_tbl_d[issue_id_q] = req_head_s.msg.opaque;
      issue_id_d               = issue_id_q + ID_ONE;
    end else begin
      issue_id_d = issue_id_q;
    end
    if (resp_fire_s) begin
      expect_id_d = expect_id_q + ID_ONE;
      if (resp_id_s != expect_id_q) begin
        err_seq_d = 1'b1;
      end else begin
        err_seq_d = err_seq_q;
      end
    end else begin
      expect_id_d = expect_id_q;
    end
    case ({issue_fire_s, resp_fire_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
    drain_done_d = drain
                 && (req_count_s == {RQ_CW{1'b0}})
                 && (resp_count_s == {RS_CW{1'b0}})
                 && (outstanding_q == CNT_ZERO);
  end

`ifdef CACHE_MEM_BRIDGE_STATS_EN
  // Statistics: issued requests and cycles held back by the outstanding limit.
  always_comb begin
    stat_req_d   = stat_req_q;
    stat_stall_d = stat_stall_q;
    if (issue_fire_s) begin
      stat_req_d = stat_req_q + 32'd1;
    end else begin
      stat_req_d = stat_req_q;
    end
    if (!memreq_val && !req_empty_s) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_req_q   <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      stat_req_q   <= stat_req_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_req_cnt   = stat_req_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

  // Control registers; reset discards all in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_id_q    <= {ID_W{1'b0}};
      expect_id_q   <= {ID_W{1'b0}};
      outstanding_q <= CNT_ZERO;
      err_seq_q     <= 1'b0;
      drain_done_q  <= 1'b0;
    end else begin
      issue_id_q    <= issue_id_d;
      expect_id_q   <= expect_id_d;
      outstanding_q <= outstanding_d;
      err_seq_q     <= err_seq_d;
      drain_done_q  <= drain_done_d;
    end
  end

  // Opaque table; a slot is always written before its id can come back.
  always_ff @(posedge clk) begin
    opaque_tbl_q <= opaque_tbl_d;
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Self-checking bench for cache_mem_bridge: the bench plays cache and memory,
// and a queue-based reference model predicts every handshake and message.
module tb_cache_mem_bridge;
  import cache_mem_bridge_pkg::*;

  localparam int MAXO = 4;
  localparam int RQD  = 4;
  localparam int RSD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         cachereq_val, cachereq_rdy;
  mem_req_4B_t  cachereq_msg;
  logic         cacheresp_val, cacheresp_rdy;
  mem_resp_4B_t cacheresp_msg;
  logic         memreq_val, memreq_rdy;
  mem_req_4B_t  memreq_msg;
  logic         memresp_val, memresp_rdy;
  mem_resp_4B_t memresp_msg;
  logic         drain, drain_done, err_seq;
`ifdef CACHE_MEM_BRIDGE_STATS_EN
  logic [31:0]  stat_req_cnt, stat_stall_cnt;
`endif

  cache_mem_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .cachereq_val  (cachereq_val),
    .cachereq_rdy  (cachereq_rdy),
    .cachereq_msg  (cachereq_msg),
    .cacheresp_val (cacheresp_val),
    .cacheresp_rdy (cacheresp_rdy),
    .cacheresp_msg (cacheresp_msg),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memreq_msg    (memreq_msg),
    .memresp_val   (memresp_val),
    .memresp_rdy   (memresp_rdy),
    .memresp_msg   (memresp_msg),
    .drain         (drain),
    .drain_done    (drain_done),
    .err_seq       (err_seq)
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    ,
    .stat_req_cnt  (stat_req_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  typedef struct {
    mem_req_4B_t orig;
    logic [1:0]  id;
  } pend_t;

  // Reference model state
  mem_req_4B_t  m_req_q[$];
  pend_t        m_pend[$];
  mem_resp_4B_t m_resp_q[$];
  int           m_issued, m_answered;
  bit           m_err, m_dd;
  logic [31:0]  m_stat_req, m_stat_stall;

  // Stimulus state
  mem_req_4B_t  to_send[$];
  int p_creq = 100, p_mreq_rdy = 100, p_cresp_rdy = 100, p_mresp = 100;
  bit mem_en = 1'b0;
  int pick = 0;

  // Bookkeeping
  int total = 0, bad = 0;
  int cyc = 0, obs_mreq_fires = 0, last_mfire_cyc = -1, last_cfire_cyc = -1;
  mem_resp_4B_t last_cresp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  function automatic mem_req_4B_t mk(input logic [2:0] t, input logic [7:0] o,
                                     input logic [31:0] a, input logic [31:0] d);
    mem_req_4B_t r;
    r.type_ = t; r.opaque = o; r.addr = a; r.len = 2'd0; r.data = d;
    return r;
  endfunction

  function automatic mem_req_4B_t rand_req();
    return mk(3'($urandom_range(1, 0)), 8'($urandom), {$urandom} & 32'hFFFF_FFFC, $urandom);
  endfunction

  // What the bench's memory sends back for an issued request.
  function automatic mem_resp_4B_t mem_reply(input pend_t e);
    mem_resp_4B_t r;
    r.type_  = e.orig.type_;
    r.opaque = 8'(e.id);
    r.test   = 2'd0;
    r.len    = e.orig.len;
    r.data   = (e.orig.type_ == MEM_READ) ? (e.orig.addr ^ 32'hDEAD_AEEF) : 32'h0;
    return r;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle();
    int sel;
    bit e_crdy, e_mval, e_mrdy, e_cval, cf, mf, rf, of, dd_next, stall;
    mem_req_4B_t  e_mreq;
    mem_resp_4B_t r;
    pend_t        p;
    cachereq_val  = (to_send.size() > 0) && rnd(p_creq);
    cachereq_msg  = (to_send.size() > 0) ? to_send[0] : '0;
    memreq_rdy    = rnd(p_mreq_rdy);
    cacheresp_rdy = rnd(p_cresp_rdy);
    sel = 0;
    if (mem_en && m_pend.size() > 0 && rnd(p_mresp)) begin
      sel = (pick < m_pend.size()) ? pick : 0;
      memresp_val = 1'b1;
      memresp_msg = mem_reply(m_pend[sel]);
    end else begin
      memresp_val = 1'b0;
      memresp_msg = '0;
    end
    #1;
    e_crdy = reset && !drain && (m_req_q.size() < RQD);
    e_mval = reset && (m_req_q.size() > 0) && (m_pend.size() < MAXO);
    e_mrdy = reset && (m_resp_q.size() < RSD);
    e_cval = reset && (m_resp_q.size() > 0);
    chk("cachereq_rdy", cachereq_rdy, e_crdy);
    chk("memreq_val", memreq_val, e_mval);
    chk("memresp_rdy", memresp_rdy, e_mrdy);
    chk("cacheresp_val", cacheresp_val, e_cval);
    chk("err_seq", err_seq, m_err);
    chk("drain_done", drain_done, m_dd);
    if (e_mval) begin
      e_mreq = m_req_q[0];
      e_mreq.opaque = 8'(m_issued % MAXO);
      chk("memreq_msg", memreq_msg, e_mreq);
    end
    if (e_cval) chk("cacheresp_msg", cacheresp_msg, m_resp_q[0]);
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    chk("stat_req_cnt", stat_req_cnt, m_stat_req);
    chk("stat_stall_cnt", stat_stall_cnt, m_stat_stall);
`endif
    if (memreq_val && memreq_rdy) begin
      obs_mreq_fires++;
      last_mfire_cyc = cyc;
    end
    if (cacheresp_val && cacheresp_rdy) begin
      last_cresp = cacheresp_msg;
      last_cfire_cyc = cyc;
    end
    cf = cachereq_val && e_crdy;
    mf = e_mval && memreq_rdy;
    rf = memresp_val && e_mrdy;
    of = e_cval && cacheresp_rdy;
    dd_next = drain && (m_req_q.size() == 0) && (m_pend.size() == 0) && (m_resp_q.size() == 0);
    stall = !e_mval && (m_req_q.size() > 0);
    @(posedge clk);
    if (!reset) begin
      m_req_q.delete(); m_pend.delete(); m_resp_q.delete();
      m_issued = 0; m_answered = 0; m_err = 1'b0; m_dd = 1'b0;
      m_stat_req = 32'd0; m_stat_stall = 32'd0;
    end else begin
      if (of) void'(m_resp_q.pop_front());
      if (rf) begin
        p = m_pend[sel];
        m_pend.delete(sel);
        r = mem_reply(p);
        r.opaque = p.orig.opaque;
        m_resp_q.push_back(r);
        if (int'(p.id) != (m_answered % MAXO)) m_err = 1'b1;
        m_answered++;
      end
      if (mf) begin
        p.orig = m_req_q.pop_front();
        p.id   = 2'(m_issued % MAXO);
        m_pend.push_back(p);
        m_issued++;
        m_stat_req = m_stat_req + 32'd1;
      end
      if (stall) m_stat_stall = m_stat_stall + 32'd1;
      if (cf) m_req_q.push_back(to_send[0]);
      m_dd = dd_next;
    end
    if (cf) void'(to_send.pop_front());
    cyc++;
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((to_send.size() + m_req_q.size() + m_pend.size() + m_resp_q.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", (n < budget), 1'b1);
  endtask

  initial begin
    int t0, n;
    reset = 1'b0; drain = 1'b0;
    cachereq_val = 1'b0; cachereq_msg = '0; memreq_rdy = 1'b0;
    memresp_val = 1'b0; memresp_msg = '0; cacheresp_rdy = 1'b0;
    m_issued = 0; m_answered = 0; m_err = 1'b0; m_dd = 1'b0;
    m_stat_req = 32'd0; m_stat_stall = 32'd0; last_cresp = '0;
    #1;
    repeat (3) cycle();
    reset = 1'b1;

    // Single read with the documented values and latency.
    mem_en = 1'b1;
    to_send.push_back(mk(MEM_READ, 8'h5A, 32'h0000_1000, 32'h0));
    t0 = cyc;
    wait_idle(20);
    chk("t1_memreq_cycle", last_mfire_cyc - t0, 1);
    chk("t1_cresp_cycle", last_cfire_cyc - t0, 3);
    chk("t1_cresp_opaque", last_cresp.opaque, 8'h5A);
    chk("t1_cresp_data", last_cresp.data, 32'hDEADBEEF);

    // Outstanding limit: memory silent, six writes.
    mem_en = 1'b0;
    obs_mreq_fires = 0;
    for (int i = 0; i < 6; i++) to_send.push_back(mk(MEM_WRITE, 8'($urandom), 32'h2000 + 32'(i * 4), $urandom));
    repeat (14) cycle();
    chk("t2_fires_held", obs_mreq_fires, 4);
    mem_en = 1'b1;
    wait_idle(100);
    chk("t2_fires_total", obs_mreq_fires, 6);

    // Response backpressure.
    p_cresp_rdy = 0;
    for (int i = 0; i < 3; i++) to_send.push_back(mk(MEM_READ, 8'($urandom), 32'h3000 + 32'(i * 4), 32'h0));
    repeat (12) cycle();
    chk("t3_memresp_rdy", memresp_rdy, 1'b0);
    p_cresp_rdy = 100;
    wait_idle(100);

    // Out-of-order return sets the sticky error.
    mem_en = 1'b0;
    for (int i = 0; i < 2; i++) to_send.push_back(mk(MEM_READ, 8'(8'hC0 + i), 32'h4000 + 32'(i * 4), 32'h0));
    repeat (6) cycle();
    mem_en = 1'b1; pick = 1;
    cycle();
    pick = 0;
    cycle();
    chk("t4_err_set", err_seq, 1'b1);
    wait_idle(50);
    chk("t4_err_sticky", err_seq, 1'b1);

    // Drain with three requests in flight.
    mem_en = 1'b0;
    for (int i = 0; i < 3; i++) to_send.push_back(mk(MEM_READ, 8'($urandom), 32'h5000 + 32'(i * 4), 32'h0));
    repeat (5) cycle();
    drain = 1'b1;
    to_send.push_back(mk(MEM_WRITE, 8'h77, 32'h5100, 32'h1234_5678));
    cycle();
    chk("t5_rdy_refused", cachereq_rdy, 1'b0);
    mem_en = 1'b1;
    n = 0;
    while (drain_done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("t5_drain_timeout", (n < 40), 1'b1);
    drain = 1'b0;
    cycle();
    chk("t5_drain_cleared", drain_done, 1'b0);
    wait_idle(50);

    // Reset mid-flight.
    mem_en = 1'b0;
    for (int i = 0; i < 2; i++) to_send.push_back(rand_req());
    repeat (5) cycle();
    reset = 1'b0;
    to_send.delete();
    repeat (2) cycle();
    reset = 1'b1;
    mem_en = 1'b1;
    chk("t6_err_cleared", err_seq, 1'b0);
    to_send.push_back(mk(MEM_READ, 8'h33, 32'h6000, 32'h0));
    wait_idle(30);

    // Random soak.
    p_creq = 70; p_mreq_rdy = 60; p_cresp_rdy = 65; p_mresp = 60;
    for (int i = 0; i < 60; i++) to_send.push_back(rand_req());
    wait_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
